// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-limb add/subtract engine.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // IDLE: the next accepted limb is limb 0. BUSY: limbs 1..NLIMBS-1.
  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Bits needed to count limbs 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/addsub_limb.sv
// Combinational WIDTH-bit add/subtract slice with carry-in. Subtraction is
// done as a + ~b + cin, so the caller supplies the inverted borrow as cin.
module addsub_limb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout_raw,
  output logic             msb_cin
);

  logic [WIDTH-1:0] b_eff;

  // Operand conditioning, full-width sum, and recovery of the MSB carry-in.
  always_comb begin
    b_eff             = sub ? ~b : b;
    {cout_raw, sum}   = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(cin);
    // The carry entering the top bit is whatever makes a^b^carry equal sum.
    msb_cin           = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
  end

endmodule

// File: rtl/addsub_multilimb.sv
// Sequential multi-precision add/subtract: one little-endian limb per accepted
// beat, carry/borrow chained through a register, one registered result limb out.
module addsub_multilimb
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NLIMBS = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  input  logic             SUB,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             O_LAST,
  output logic             COUT,
  output logic             V
);

  localparam int            CW       = clog2(NLIMBS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NLIMBS - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic             is_first;
  logic             is_last;
  logic             mode_eff;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             cout_raw;
  logic             msb_cin;

  // A single output register: room exists when it is empty or being drained.
  assign I_READY  = !O_VALID || O_READY;
  assign accept   = I_VALID && I_READY;
  assign is_first = (state_q == IDLE);
  // The counter sits at 0 in IDLE, so this also covers NLIMBS == 1.
  assign is_last  = (cnt_q == LAST_IDX);
  // Mode and carry come from the ports on limb 0, from the registers after.
  assign mode_eff = is_first ? SUB : mode_q;
  assign c_in     = is_first ? ((SUB == MODE_SUB) ? !CIN : CIN) : carry_q;

  addsub_limb #(.WIDTH(WIDTH)) u_limb (
    .a        (I0),
    .b        (I1),
    .cin      (c_in),
    .sub      (mode_eff),
    .sum      (sum),
    .cout_raw (cout_raw),
    .msb_cin  (msb_cin)
  );

  // Operation state: phase, limb counter, chained carry and latched mode.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= MODE_ADD;
    end else begin
      // NOTE: clocked blocks use <= so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic: advance only on an accepted limb, otherwise hold.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    if (accept) begin
      mode_d  = mode_eff;
      carry_d = cout_raw;
      if (is_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // Result register: load on accept, empty when drained, else hold stable.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      // NOTE: data fields are reset too so O reads 0 out of reset; bulk storage
      // such as a RAM would normally be left unreset.
      O_VALID <= 1'b0;
      O       <= '0;
      O_LAST  <= 1'b0;
      COUT    <= 1'b0;
      V       <= 1'b0;
    end else if (accept) begin
      O_VALID <= 1'b1;
      O       <= sum;
      O_LAST  <= is_last;
      COUT    <= is_last && (mode_eff == MODE_SUB ? !cout_raw : cout_raw);
      V       <= is_last && (msb_cin ^ cout_raw);
    end else if (O_READY) begin
      O_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_multilimb.sv
// Self-checking bench: three engine configurations (8x2, 8x4, 16x1).
module tb_addsub_multilimb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // ---- 8-bit x 2 limbs ----
  logic       a_iv, a_ir, a_cin, a_sub, a_ov, a_or, a_last, a_cout, a_v;
  logic [7:0] a_i0, a_i1, a_o;
  addsub_multilimb #(.WIDTH(8), .NLIMBS(2)) u_dut2 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(a_iv), .I_READY(a_ir),
    .I0(a_i0), .I1(a_i1), .CIN(a_cin), .SUB(a_sub), .O_VALID(a_ov),
    .O_READY(a_or), .O(a_o), .O_LAST(a_last), .COUT(a_cout), .V(a_v));

  // ---- 8-bit x 4 limbs ----
  logic       d_iv, d_ir, d_cin, d_sub, d_ov, d_or, d_last, d_cout, d_v;
  logic [7:0] d_i0, d_i1, d_o;
  addsub_multilimb #(.WIDTH(8), .NLIMBS(4)) u_dut4 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(d_iv), .I_READY(d_ir),
    .I0(d_i0), .I1(d_i1), .CIN(d_cin), .SUB(d_sub), .O_VALID(d_ov),
    .O_READY(d_or), .O(d_o), .O_LAST(d_last), .COUT(d_cout), .V(d_v));

  // ---- 16-bit x 1 limb ----
  logic        e_iv, e_ir, e_cin, e_sub, e_ov, e_or, e_last, e_cout, e_v;
  logic [15:0] e_i0, e_i1, e_o;
  addsub_multilimb #(.WIDTH(16), .NLIMBS(1)) u_dut1 (
    .CLK(clk), .ASYNCRESETN(rst_n), .I_VALID(e_iv), .I_READY(e_ir),
    .I0(e_i0), .I1(e_i1), .CIN(e_cin), .SUB(e_sub), .O_VALID(e_ov),
    .O_READY(e_or), .O(e_o), .O_LAST(e_last), .COUT(e_cout), .V(e_v));

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    logic        c;
    logic        v;
  } vec_t;

  typedef struct packed {
    logic [63:0] r;
    logic        c;
    logic        v;
  } res_t;

  typedef struct packed {
    logic [7:0] o;
    logic       last;
    logic       c;
    logic       v;
  } limb_t;

  localparam int NOPS4 = 40;

  vec_t        tbl[8];
  limb_t       exp_q[$];
  logic [31:0] x4[NOPS4];
  logic [31:0] y4[NOPS4];
  logic        sub4[NOPS4];
  logic        cin4[NOPS4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on 'bits'-wide two's-complement values.
  function automatic res_t model(input int bits, input logic sub, input logic cin,
                                 input logic [63:0] x, input logic [63:0] y);
    logic [64:0] t;
    logic [63:0] mask;
    logic        xs, ys, s;
    res_t        res;
    mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
    x = x & mask;
    y = y & mask;
    if (!sub) t = {1'b0, x} + {1'b0, y} + 65'(cin);
    else      t = {1'b0, x} - {1'b0, y} - 65'(cin);
    res.r = t[63:0] & mask;
    res.c = t[bits];           // carry out, or borrow (wrap below zero)
    xs = x[bits-1];
    ys = y[bits-1];
    s  = t[bits-1];
    res.v = sub ? ((xs != ys) && (s != xs)) : ((xs == ys) && (s != xs));
    return res;
  endfunction

  // One 2-limb operation with the output always ready; SUB/CIN toggled on limb 1.
  task automatic run_op2(input int idx, input vec_t t);
    logic [15:0] r;
    @(negedge clk);
    a_or = 1'b1; a_iv = 1'b1;
    a_i0 = t.x[7:0]; a_i1 = t.y[7:0]; a_sub = t.sub; a_cin = t.cin;
    #1 check($sformatf("tbl%0d_irdy", idx), a_ir, 1);
    @(negedge clk);
    check($sformatf("tbl%0d_l0", idx), {a_ov, a_last}, 2'b10);
    r[7:0] = a_o;
    a_i0 = t.x[15:8]; a_i1 = t.y[15:8]; a_sub = ~t.sub; a_cin = ~t.cin;
    @(negedge clk);
    check($sformatf("tbl%0d_l1", idx), {a_ov, a_last}, 2'b11);
    r[15:8] = a_o;
    a_iv = 1'b0;
    check($sformatf("tbl%0d_res", idx), {r, a_cout, a_v}, {t.r, t.c, t.v});
  endtask

  // Random limb driver for the 4-limb engine with idle gaps.
  task automatic drive4();
    int op = 0, k = 0, budget = 0;
    while (op < NOPS4 && budget < 5000) begin
      @(negedge clk);
      budget++;
      if ($urandom_range(0, 3) == 0) begin
        d_iv = 1'b0;
      end else begin
        d_iv  = 1'b1;
        d_i0  = x4[op][8*k +: 8];
        d_i1  = y4[op][8*k +: 8];
        d_sub = (k == 0) ? sub4[op] : 1'($urandom);
        d_cin = (k == 0) ? cin4[op] : 1'($urandom);
        #1;
        if (d_ir) begin
          k++;
          if (k == 4) begin k = 0; op++; end
        end
      end
    end
    @(negedge clk);
    d_iv = 1'b0;
    if (op < NOPS4) check("drv4_timeout", op, NOPS4);
  endtask

  // Random-backpressure monitor comparing each drained limb to the scoreboard.
  task automatic mon4(input int total);
    int    got = 0, budget = 0;
    limb_t e;
    while (got < total && budget < 6000) begin
      @(negedge clk);
      budget++;
      d_or = ($urandom_range(0, 3) != 0);
      #1;
      if (d_ov && d_or) begin
        if (exp_q.size() == 0) begin
          check("mon4_extra_limb", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("n4_limb%0d", got), {d_o, d_last, d_cout, d_v}, e);
        end
        got++;
      end
    end
    if (got < total) check("mon4_timeout", got, total);
    d_or = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    res_t pe;
    limb_t l;

    tbl[0] = '{1'b0, 1'b0, 16'h01FF, 16'h0001, 16'h0200, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFE, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};

    {a_iv, a_cin, a_sub, a_or, a_i0, a_i1} = '0;
    {d_iv, d_cin, d_sub, d_or, d_i0, d_i1} = '0;
    {e_iv, e_cin, e_sub, e_or, e_i0, e_i1} = '0;
    rst_n = 1'b0;
    #12;
    check("rst_n2", {a_ov, a_o, a_last, a_cout, a_v}, '0);
    check("rst_n4", {d_ov, d_o, d_last, d_cout, d_v}, '0);
    check("rst_n1", {e_ov, e_o, e_last, e_cout, e_v}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on the 2-limb engine.
    for (int i = 0; i < 8; i++) run_op2(i, tbl[i]);

    // Backpressure: three stalled cycles, then back-to-back streaming.
    @(negedge clk);
    a_or = 1'b0; a_iv = 1'b1;
    a_i0 = 8'hFF; a_i1 = 8'h01; a_sub = 1'b0; a_cin = 1'b0;
    #1 check("bp_irdy0", a_ir, 1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", s), {a_ov, a_o, a_last}, {1'b1, 8'h00, 1'b0});
      if (s == 0) begin
        a_i0 = 8'h01; a_i1 = 8'h00; a_sub = 1'b1; a_cin = 1'b1;
      end
      #1 check($sformatf("bp_stall%0d", s), a_ir, 0);
    end
    @(negedge clk);
    a_or = 1'b1;
    #1 check("bp_release", {a_ir, a_ov, a_o}, {1'b1, 1'b1, 8'h00});
    @(negedge clk);
    check("bp_a_l1", {a_ov, a_o, a_last, a_cout, a_v}, {1'b1, 8'h02, 1'b1, 1'b0, 1'b0});
    a_i0 = 8'h00; a_i1 = 8'h01; a_sub = 1'b1; a_cin = 1'b0;
    @(negedge clk);
    check("bp_b_l0", {a_ov, a_o, a_last}, {1'b1, 8'hFF, 1'b0});
    a_i0 = 8'h80; a_i1 = 8'h00; a_sub = 1'b0; a_cin = 1'b1;
    @(negedge clk);
    check("bp_b_l1", {a_ov, a_o, a_last, a_cout, a_v}, {1'b1, 8'h7F, 1'b1, 1'b0, 1'b1});
    a_iv = 1'b0;
    @(negedge clk);
    check("bp_drained", a_ov, 0);

    // Reset between clock edges after limb 1 of 4.
    @(negedge clk);
    d_or = 1'b1; d_iv = 1'b1; d_i0 = 8'h44; d_i1 = 8'h11; d_sub = 1'b0; d_cin = 1'b0;
    @(negedge clk);
    d_i0 = 8'h33; d_i1 = 8'h22;
    @(posedge clk);
    #3;
    check("rst_mid_pre", {d_ov, d_o, d_last}, {1'b1, 8'h55, 1'b0});
    d_iv = 1'b0;
    rst_n = 1'b0;
    #1 check("rst_mid_now", {d_ov, d_o, d_last, d_cout, d_v}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_quiet", d_ov, 0);

    // Randomised 32-bit operations on the 4-limb engine vs the word model.
    for (int i = 0; i < NOPS4; i++) begin
      x4[i]   = $urandom;
      y4[i]   = (i % 5 == 0) ? ~x4[i] : $urandom;
      sub4[i] = 1'($urandom);
      cin4[i] = 1'($urandom);
      pe = model(32, sub4[i], cin4[i], {32'd0, x4[i]}, {32'd0, y4[i]});
      for (int k = 0; k < 4; k++) begin
        l.o    = pe.r[8*k +: 8];
        l.last = (k == 3);
        l.c    = (k == 3) ? pe.c : 1'b0;
        l.v    = (k == 3) ? pe.v : 1'b0;
        exp_q.push_back(l);
      end
    end
    fork
      drive4();
      mon4(NOPS4 * 4);
    join
    @(negedge clk);
    check("n4_idle_after", {d_ov, 32'(exp_q.size())}, '0);

    // Single-limb 16-bit engine: directed case, then back-to-back random beats.
    @(negedge clk);
    e_or = 1'b1; e_iv = 1'b1; e_i0 = 16'h1234; e_i1 = 16'hEDCC; e_sub = 1'b0; e_cin = 1'b0;
    @(negedge clk);
    check("n1_dir", {e_ov, e_o, e_last, e_cout, e_v}, {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check($sformatf("n1_rand%0d", i - 1), {e_ov, e_ir, e_o, e_last, e_cout, e_v},
              {1'b1, 1'b1, pe.r[15:0], 1'b1, pe.c, pe.v});
      end
      if (i < 24) begin
        e_i0  = 16'($urandom);
        e_i1  = (i % 4 == 0) ? 16'h8000 : 16'($urandom);
        e_sub = 1'($urandom);
        e_cin = 1'($urandom);
        pe = model(16, e_sub, e_cin, {48'd0, e_i0}, {48'd0, e_i1});
      end else begin
        e_iv = 1'b0;
      end
    end
    @(negedge clk);
    check("n1_drained", e_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/addsub_multilimb.md
Name: addsub_multilimb

Overview:
- Parametrised multi-precision add/subtract engine, the sequential successor of the fixed 8-bit add/sub-with-carry-in cells.
- Operands arrive as NLIMBS little-endian limbs of WIDTH bits, one limb per accepted beat.
- The carry/borrow is held in a register and chained between beats. Each result limb is emitted on a registered valid/ready output.
- Sits between operand streamers and the result writer in the arithmetic datapath.

Parameters:
WIDTH, 8, limb width in bits (>=2)
NLIMBS, 4, limbs per operation (>=1); total operand width WIDTH*NLIMBS

Ports:
CLK  input  1  clock, all state on rising edge
ASYNCRESETN  input  1  asynchronous, active-low reset
I_VALID  input  1  input limb valid
I_READY  output  1  engine accepts input limb this cycle
I0  input  WIDTH  minuend/augend limb
I1  input  WIDTH  subtrahend/addend limb
CIN  input  1  carry-in (ADD) / borrow-in (SUB); sampled on first limb only
SUB  input  1  0=ADD, 1=SUB; sampled on first limb only
O_VALID  output  1  result limb valid
O_READY  input  1  downstream accepts result limb
O  output  WIDTH  result limb
O_LAST  output  1  O is the final (most significant) limb
COUT  output  1  ADD: carry-out; SUB: borrow-out; meaningful only when O_VALID&O_LAST
V  output  1  signed overflow of the full-width result; meaningful only when O_VALID&O_LAST

Behaviour:
- Reset (ASYNCRESETN=0, immediate):
  - O_VALID=0, O=0, O_LAST=0, COUT=0, V=0.
  - State=IDLE, limb counter=0, carry reg=0, mode reg=0.
  - Reset mid-operation discards the partial operation; no output follows.
- Handshakes:
  - Input transfer when I_VALID&I_READY. Output transfer when O_VALID&O_READY.
  - I_READY = !O_VALID | O_READY: single output register, full throughput, combinational path only from O_READY.
  - O, O_LAST, COUT and V are held stable while O_VALID&!O_READY.
- States:
  - IDLE: next accepted limb is limb 0. On accept, latch mode=SUB. Effective carry c0 = SUB ? !CIN : CIN.
    - NLIMBS>1: go to BUSY, counter=1.
    - NLIMBS==1: stay IDLE.
  - BUSY: limbs 1..NLIMBS-1. SUB and CIN are ignored here; latched mode is used.
    - Accepting limb NLIMBS-1 returns to IDLE and clears the counter.
    - The counter increments on every input accept in BUSY.
- Arithmetic per accepted limb, with c = c0 on limb 0, else carry reg:
  - B = mode ? ~I1 : I1.
  - {cout_raw, sum} = I0 + B + c, computed at WIDTH+1 bits.
  - O <= sum; carry reg <= cout_raw.
  - O_LAST <= (this is limb NLIMBS-1).
  - COUT <= mode ? !cout_raw : cout_raw, on the last limb; 0 otherwise.
  - V <= carry into bit WIDTH-1 XOR cout_raw, on the last limb; 0 otherwise.
  - SUB therefore computes I0 - I1 - CIN, modulo 2^(WIDTH*NLIMBS).
- Latency: one cycle from input accept to O_VALID.
- Boundary cases:
  - Back-to-back operations need no bubble.
  - The first limb of operation N+1 may be accepted in the same cycle the last limb of operation N is taken downstream.
  - No input without I_VALID means no state change; an operation may stall indefinitely between limbs.

Decomposition:
- Shared package addsub_pkg holds:
  - mode encoding constants (MODE_ADD=0, MODE_SUB=1);
  - state enum (IDLE, BUSY);
  - the counter-width function clog2(NLIMBS) with a minimum of 1.
- One natural sub-module: addsub_limb, a combinational WIDTH-bit add/sub with carry-in that returns sum, cout_raw and the MSB carry-in. It generalises the existing fixed 8-bit cells. The top level holds the FSM, counter, carry register and output register.

Test Plan:
- Carry across limbs (WIDTH=8, NLIMBS=2): ADD, I0 limbs 0xFF,0x01, I1 limbs 0x01,0x00, CIN=0 -> O=0x00 then 0x02 (O_LAST=1), COUT=0, V=0.
- Borrow (NLIMBS=2): SUB, 0x0000-0x0001, CIN=0 -> O=0xFF,0xFF, COUT=1, V=0. Repeat with CIN=1 -> 0xFE,0xFF, COUT=1.
- Signed overflow (NLIMBS=2): ADD, 0x7FFF+0x0001 -> O=0x00,0x80, V=1, COUT=0. SUB, 0x8000-0x0001 -> 0xFF,0x7F, V=1, COUT=0.
- Backpressure: O_READY=0 for 3 cycles with I_VALID held -> I_READY=0, outputs stable, no limb lost. Release -> full-rate streaming of two back-to-back operations. Also check SUB/CIN changes mid-operation are ignored.
- Reset mid-operation: assert ASYNCRESETN=0 after limb 1 of 4 (between clock edges) -> O_VALID drops immediately. A new operation after reset computes correctly from limb 0.
- NLIMBS=1, WIDTH=16: 0x1234+0xEDCC with CIN=0 -> O=0x0000, O_LAST=1, COUT=1. Every beat is IDLE-to-IDLE.
